// File: rtl/enemy_pkg.sv
// enemy_pkg: shared screen geometry, sprite defaults and colours for the enemy datapath
package enemy_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPRITE_W_DEF = 4;
  localparam int SPRITE_H_DEF = 4;
  localparam int STEP_Y_DEF = 4;
  localparam int DELAY_CYCLES_DEF = 833333;
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_ENEMY = 3'b100;
endpackage

// File: rtl/datapath_enemy_frame_delay.sv
// frame_delay: move-step delay counter, strobes hold once every DELAY_CYCLES enabled cycles
// ports: clk, reset (async, active-high), reset_C (active-low sync clear),
//        en_de (count enable), hold (interval elapsed this cycle)
module frame_delay #(
  parameter int DELAY_CYCLES = 833333
) (
  input  logic clk,
  input  logic reset,
  input  logic reset_C,
  input  logic en_de,
  output logic hold
);
  logic [19:0] del_cnt;
  assign hold = reset_C && en_de && (del_cnt == 20'(DELAY_CYCLES - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) del_cnt <= '0;
    else if (!reset_C) del_cnt <= '0;
    else if (en_de) del_cnt <= hold ? '0 : del_cnt + 20'd1;
endmodule

// File: rtl/datapath_enemy.sv
// datapath_enemy: enemy sprite position, bounce motion, pixel emission and move-step delay
// ports: clk, reset (async, active-high); from control FSM: reset_C, en_de, en_XY, plot, erase;
//        to control FSM: done (last pixel now), hold (delay elapsed now);
//        to VGA: x_out, y_out, colour_out, writeEn
module datapath_enemy
  import enemy_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int SPRITE_H = SPRITE_H_DEF,
  parameter int DELAY_CYCLES = DELAY_CYCLES_DEF,
  parameter int INIT_X = 0,
  parameter int INIT_Y = 0,
  parameter int STEP_Y = STEP_Y_DEF,
  parameter logic [2:0] ENEMY_COLOUR = COL_ENEMY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reset_C,
  input  logic       en_de,
  input  logic       en_XY,
  input  logic       plot,
  input  logic       erase,
  output logic       done,
  output logic       hold,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       writeEn
);
  localparam int PIX_N = SPRITE_W * SPRITE_H;
  localparam int PW = PIX_N > 1 ? $clog2(PIX_N) : 1;
  localparam int X_MAX = SCREEN_W - SPRITE_W;
  localparam int Y_MAX = SCREEN_H - SPRITE_H;
  logic [7:0] x;
  logic [6:0] y;
  logic dir;
  logic [PW-1:0] pix_cnt;
  logic [7:0] y_sum;
  logic [6:0] y_adv;
  assign y_sum = {1'b0, y} + 8'(STEP_Y);
  assign y_adv = (y_sum <= 8'(Y_MAX)) ? y_sum[6:0] : '0;
  assign done = plot && (pix_cnt == PW'(PIX_N - 1));
  assign x_out = 8'(32'(x) + 32'(pix_cnt) % SPRITE_W);
  assign y_out = 7'(32'(y) + 32'(pix_cnt) / SPRITE_W);
  assign writeEn = plot;
  assign colour_out = erase ? COL_BLACK : ENEMY_COLOUR;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      x <= 8'(INIT_X);
      y <= 7'(INIT_Y);
      dir <= 1'b1;
      pix_cnt <= '0;
    end else begin
      pix_cnt <= (plot && !done) ? pix_cnt + PW'(1) : '0;
      if (en_XY) begin
        if (dir) begin
          if (x < 8'(X_MAX)) x <= x + 8'd1;
          else begin
            dir <= 1'b0;
            y <= y_adv;
          end
        end else begin
          if (x > 8'd0) x <= x - 8'd1;
          else begin
            dir <= 1'b1;
            y <= y_adv;
          end
        end
      end
    end
  frame_delay #(.DELAY_CYCLES(DELAY_CYCLES)) u_delay (
    .clk(clk),
    .reset(reset),
    .reset_C(reset_C),
    .en_de(en_de),
    .hold(hold)
  );
endmodule
